pixel_blend_stream: RTL
=======================

PIXEL_BLEND_STREAM -- requirements
Module: pixel_blend_stream

Interface
REQ-001 Parameter NUM_PIXELS, default 90000: pixels per frame (300x300 image).
REQ-002 Parameter CNT_W, default 17: pixel counter width; SHALL satisfy 2^CNT_W >= NUM_PIXELS.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1: sole clock, rising edge.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port start, input, 1: one-cycle pulse, begins a frame; ignored unless state IDLE.
REQ-007 Port weight_a, input, 8: image1 weight; sampled on accepted start.
REQ-008 Port weight_b, input, 8: image2 weight; sampled on accepted start.
REQ-009 Port in_valid, input, 1: pix_a/pix_b valid.
REQ-010 Port in_ready, output, 1: block accepts a pixel pair this cycle.
REQ-011 Port pix_a, input, 8: image1 pixel.
REQ-012 Port pix_b, input, 8: image2 pixel.
REQ-013 Port out_valid, output, 1: out_pix valid.
REQ-014 Port out_ready, input, 1: downstream accepts out_pix.
REQ-015 Port out_pix, output, 8: blended pixel.
REQ-016 Port out_last, output, 1: high with the final pixel of the frame.
REQ-017 Port busy, output, 1: high in RUN and DRAIN.
REQ-018 Port done, output, 1: one-cycle pulse after the last output handshake.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN. IDLE->RUN on start; RUN->DRAIN when input pixel NUM_PIXELS-1 is accepted; DRAIN->IDLE on the out_last handshake, asserting done in the following cycle.
REQ-020 Input handshake SHALL occur when in_valid && in_ready; in_ready = (state==RUN) && !stall.
REQ-021 stall = out_valid && !out_ready; while stalled, all pipeline registers SHALL hold.
REQ-022 Stage 1 registers pix_a and pix_b; two multiplier3 instances compute pix_a*weight_a and pix_b*weight_b (16-bit y).
REQ-023 Stage 2 registers y[15:8] of each product, so the 8-bit fractional weighting matches the offline blend flow.
REQ-024 Output register: out_pix = saturating sum of the two high bytes; a 9-bit sum >255 SHALL yield 8'hFF (no wrap).
REQ-025 Latency SHALL be exactly 3 cycles from input handshake to out_valid with no stall; throughput is 1 pixel per cycle.
REQ-026 The input counter SHALL increment per accepted pair and clear at start; the output counter SHALL increment per output handshake; out_last is asserted when output count == NUM_PIXELS-1.
REQ-027 in_valid in IDLE or DRAIN SHALL be ignored; start during RUN/DRAIN SHALL be ignored.
REQ-028 Pipeline valid bits SHALL propagate with the data; no bubble SHALL be emitted as out_valid.

Reset
REQ-029 On rst all registers SHALL clear: state IDLE, counters 0, weights 0, out_pix 0, out_valid 0, out_last 0, done 0, busy 0, in_ready 0.
REQ-030 rst mid-frame SHALL abandon the frame immediately; no out_valid and no done SHALL follow until a new start.

Structure
REQ-031 A shared package (blend_pkg) SHALL hold the FSM state encoding, PIX_W=8, PROD_W=16 and the default NUM_PIXELS.
REQ-032 multiplier3 (A, B, y) SHALL be the single sub-module, instantiated twice, unmodified.

Verification
REQ-033 weight_a=weight_b=8'h80, pixels a=8'h40, b=8'h20, no stall -> out_pix equals the model sum of multiplier3 high bytes (8'h30 if exact), 3 cycles after the handshake.
REQ-034 weights 8'hFF/8'hFF, a=b=8'hFF -> out_pix=8'hFF (saturated, not 8'hFC wrap).
REQ-035 NUM_PIXELS=4, continuous stream -> 4 outputs, out_last on the 4th, done pulses exactly one cycle after it, state IDLE.
REQ-036 out_ready held low 5 cycles mid-stream -> in_ready low, out_pix and out_valid stable, no pixel lost or duplicated.
REQ-037 rst asserted after 2 of 4 pixels -> outputs cleared asynchronously; a new start then yields a full 4-pixel frame.
REQ-038 Full 90000-pixel frame from image1_pixel_hex.txt/image2_pixel_hex.txt -> dump matches the multiplier3 behavioural model bit-exactly.

Source files
------------

// File: rtl/blend_pkg.sv
// Shared types, widths and helpers for the two-image pixel blend stream.
package blend_pkg;

    localparam int unsigned PIX_W          = 8;
    localparam int unsigned PROD_W         = 16;
    localparam int unsigned DEF_NUM_PIXELS = 90000;
    localparam int unsigned DEF_CNT_W      = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [PIX_W-1:0] a;
        logic [PIX_W-1:0] b;
    } pix_pair_t;

    // Add two bytes, clamping to all-ones instead of wrapping.
    function automatic logic [PIX_W-1:0] sat_add(input logic [PIX_W-1:0] x,
                                                 input logic [PIX_W-1:0] y);
        logic [PIX_W:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        return sum[PIX_W] ? {PIX_W{1'b1}} : sum[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/multiplier3.sv
// Unsigned 8x8 -> 16 combinational multiplier shared with the offline blend flow.
module multiplier3 (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] y
);

    assign y = 16'(A) * 16'(B);

endmodule

// File: rtl/pixel_blend_stream.sv
// Streams two images through a 3-stage weighted blend: register, weight-multiply, saturating add.
module pixel_blend_stream
    import blend_pkg::*;
#(
    parameter int unsigned NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] weight_a,
    input  logic [PIX_W-1:0] weight_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] pix_a,
    input  logic [PIX_W-1:0] pix_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

    state_t            state, state_nxt;
    logic [PIX_W-1:0]  wa_q, wb_q;
    logic [CNT_W-1:0]  in_cnt, out_cnt, out_cnt_nxt_c;
    pix_pair_t         s1;
    logic              s1_valid;
    logic [PROD_W-1:0] prod_a, prod_b;
    logic [PIX_W-1:0]  s2_a, s2_b;
    logic              s2_valid;
    logic              stall_c, in_hs_c, out_hs_c, start_acc_c;
    logic              unused_prod_lo;

    assign stall_c     = out_valid && !out_ready;
    assign in_ready    = (state == ST_RUN) && !stall_c;
    assign in_hs_c     = in_valid && in_ready;
    assign out_hs_c    = out_valid && out_ready;
    assign start_acc_c = start && (state == ST_IDLE);

    // Only the high byte of each product feeds the blend.
    assign unused_prod_lo = ^{prod_a[PIX_W-1:0], prod_b[PIX_W-1:0]};

    multiplier3 u_mul_a (.A(s1.a), .B(wa_q), .y(prod_a));
    multiplier3 u_mul_b (.A(s1.b), .B(wb_q), .y(prod_b));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
            done  <= (state == ST_DRAIN) && out_hs_c && out_last;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (in_hs_c && (in_cnt == LAST_IDX)) state_nxt = ST_DRAIN;
            ST_DRAIN: if (out_hs_c && out_last) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output count after this cycle's handshake; wraps to 0 after the final pixel.
    always_comb begin
        out_cnt_nxt_c = out_cnt;
        if (start_acc_c) begin
            out_cnt_nxt_c = '0;
        end else if (out_hs_c) begin
            out_cnt_nxt_c = out_last ? '0 : out_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wa_q    <= '0;
            wb_q    <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            out_cnt <= out_cnt_nxt_c;
            if (start_acc_c) begin
                wa_q   <= weight_a;
                wb_q   <= weight_b;
                in_cnt <= '0;
            end else if (in_hs_c) begin
                in_cnt <= in_cnt + CNT_W'(1);
            end
        end
    end

    // Pipeline stages advance together and all hold while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= '0;
            s1_valid  <= 1'b0;
            s2_a      <= '0;
            s2_b      <= '0;
            s2_valid  <= 1'b0;
            out_pix   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (!stall_c) begin
            s1_valid <= in_hs_c;
            if (in_hs_c) begin
                s1.a <= pix_a;
                s1.b <= pix_b;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_a <= prod_a[PROD_W-1 -: PIX_W];
                s2_b <= prod_b[PROD_W-1 -: PIX_W];
            end
            out_valid <= s2_valid;
            out_last  <= s2_valid && (out_cnt_nxt_c == LAST_IDX);
            if (s2_valid) begin
                out_pix <= sat_add(s2_a, s2_b);
            end
        end
    end

endmodule
